// File: rtl/demux2x8_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 byte demultiplexer.
package demux2x8_buf_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NPORTS = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef logic [BYTE_W-1:0] byte_t;

    // Per-FIFO handshake status gathered by the top level.
    typedef struct packed {
        logic full;
        logic empty;
    } fifo_status_t;

    // Accept counter step; wraps 255 -> 0 by plain modular arithmetic.
    function automatic byte_t count_next(input byte_t cnt, input logic inc);
        return inc ? byte_t'(cnt + byte_t'(1)) : cnt;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Byte FIFO with AW+1 bit pointers; the extra MSB tells full from empty.
module demux_fifo
    import demux2x8_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  byte_t wdata,
    output byte_t rdata,
    output logic  full,
    output logic  empty
);

    byte_t         mem [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          push_en;
    logic          pop_en;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    // Guard locally so a stray request can never corrupt the pointers.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign rdata = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_en) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: stale entries are masked by empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/demux2x8_buf.sv
// Buffered 1-to-2 byte demultiplexer: routes each accepted byte to one of two FIFOs.
module demux2x8_buf
    import demux2x8_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_address,
    input  logic [7:0] in_data,
    output logic       out0_valid,
    input  logic       out0_ready,
    output logic [7:0] out0_data,
    output logic       out1_valid,
    input  logic       out1_ready,
    output logic [7:0] out1_data,
    output logic [7:0] count0,
    output logic [7:0] count1
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_status_t      status [NPORTS];
    logic              push   [NPORTS];
    logic              pop    [NPORTS];
    byte_t             rdata  [NPORTS];
    logic              accept;
    byte_t             count0_q, count0_d;
    byte_t             count1_q, count1_d;

    // Head-of-line: only the addressed FIFO matters; held low during reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            unique case (in_address)
                PORT0:   in_ready = !status[0].full;
                PORT1:   in_ready = !status[1].full;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept  = in_valid && in_ready;
    assign push[0] = accept && (in_address == PORT0);
    assign push[1] = accept && (in_address == PORT1);
    assign pop[0]  = out0_ready && !status[0].empty;
    assign pop[1]  = out1_ready && !status[1].empty;

    demux_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[0]),
        .pop   (pop[0]),
        .wdata (in_data),
        .rdata (rdata[0]),
        .full  (status[0].full),
        .empty (status[0].empty)
    );

    demux_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[1]),
        .pop   (pop[1]),
        .wdata (in_data),
        .rdata (rdata[1]),
        .full  (status[1].full),
        .empty (status[1].empty)
    );

    assign out0_valid = !status[0].empty;
    assign out1_valid = !status[1].empty;
    assign out0_data  = rdata[0];
    assign out1_data  = rdata[1];

    always_comb begin
        count0_d = count_next(count0_q, push[0]);
        count1_d = count_next(count1_q, push[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign count0 = count0_q;
    assign count1 = count1_q;

endmodule
